// File: rtl/tt_mux_pkg.sv
// Shared constants and types for the registered 4-channel byte mux.
package tt_mux_pkg;
  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int AW  = $clog2(NCH);

  // uio_in control field positions
  localparam int SEL_LSB   = 0;
  localparam int INV_BIT   = 2;
  localparam int BYP_BIT   = 3;
  localparam int WADDR_LSB = 5;
  localparam int WR_BIT    = 7;

  typedef logic [DW-1:0] chan_t;
endpackage

// File: rtl/mux_regfile.sv
// Channel register file: one write port, one combinational read port.
// A read in the same cycle as a write to that channel returns the old value.
module mux_regfile
  import tt_mux_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          wr,
  input  logic [AW-1:0] waddr,
  input  chan_t         wdata,
  input  logic [AW-1:0] sel,
  output chan_t         rdata
);

  logic [NCH-1:0][DW-1:0] ch_q;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    // Load this channel when enabled and addressed
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                 ch_q[c] <= '0;
      else if (ena && wr && (waddr == AW'(c)))    ch_q[c] <= wdata;
    end
  end

  assign rdata = ch_q[sel];

endmodule

// File: rtl/tt_um_mux.sv
// TinyTapeout top: registered 4-channel byte mux with bypass and invert.
// uio pins are inputs only; uio_in[4] is reserved.
module tt_um_mux
  import tt_mux_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [AW-1:0] sel, waddr;
  logic          inv, byp, wr;
  chan_t         rdata, src, out_q;
  logic          unused_rsvd;

  assign sel         = uio_in[SEL_LSB +: AW];
  assign waddr       = uio_in[WADDR_LSB +: AW];
  assign inv         = uio_in[INV_BIT];
  assign byp         = uio_in[BYP_BIT];
  assign wr          = uio_in[WR_BIT];
  assign unused_rsvd = uio_in[4];

  mux_regfile u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .wr    (wr),
    .waddr (waddr),
    .wdata (ui_in),
    .sel   (sel),
    .rdata (rdata)
  );

  assign src = byp ? ui_in : rdata;

  // Register the selected (optionally inverted) byte; holds while ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   out_q <= '0;
    else if (ena) out_q <= inv ? ~src : src;
  end

  assign uo_out  = out_q;
  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_um_mux.sv
// Directed bench for tt_um_mux: reset, channel R/W, bypass/invert,
// same-channel hazard, write+bypass, ena gating, mid-run reset.
module tb_tt_um_mux;
  logic       clk, rst_n, ena;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
  int         n_pass = 0, n_tot = 0;

  tt_um_mux dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
  endtask

  // uio_in encoding helper: {wr, waddr[1:0], rsvd, byp, inv, sel[1:0]}
  function automatic logic [7:0] ctl(input logic w, input logic [1:0] wa,
                                     input logic b, input logic i, input logic [1:0] s);
    return {w, wa, 1'b0, b, i, s};
  endfunction

  initial begin
    logic [7:0] wv [4];
    wv[0] = 8'h11; wv[1] = 8'h22; wv[2] = 8'h33; wv[3] = 8'h44;

    // Reset asserted mid-cycle with all inputs high
    rst_n = 1'b1; ena = 1'b1; ui_in = 8'hFF; uio_in = 8'hFF;
    tick();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_uo",      uo_out,  8'h00);
    chk("rst_uio_oe",  uio_oe,  8'h00);
    chk("rst_uio_out", uio_out, 8'h00);
    tick();
    chk("rst_hold", uo_out, 8'h00);
    #2 rst_n = 1'b1;
    ui_in = 8'h00; uio_in = 8'h00;

    // Write all channels
    for (int c = 0; c < 4; c++) begin
      ui_in  = wv[c];
      uio_in = ctl(1'b1, 2'(c), 1'b0, 1'b0, 2'd0);
      tick();
    end
    ui_in = 8'h00;

    // Read back each channel
    uio_in = ctl(1'b0, 2'd0, 1'b0, 1'b0, 2'd0); tick(); chk("rd_ch0", uo_out, 8'h11);
    uio_in = ctl(1'b0, 2'd0, 1'b0, 1'b0, 2'd1); tick(); chk("rd_ch1", uo_out, 8'h22);
    uio_in = ctl(1'b0, 2'd0, 1'b0, 1'b0, 2'd2); tick(); chk("rd_ch2", uo_out, 8'h33);
    uio_in = ctl(1'b0, 2'd0, 1'b0, 1'b0, 2'd3); tick(); chk("rd_ch3", uo_out, 8'h44);

    // Bypass and invert
    ui_in = 8'hA5;
    uio_in = ctl(1'b0, 2'd0, 1'b1, 1'b0, 2'd0); tick(); chk("byp",     uo_out, 8'hA5);
    uio_in = ctl(1'b0, 2'd0, 1'b1, 1'b1, 2'd0); tick(); chk("byp_inv", uo_out, 8'h5A);
    uio_in = ctl(1'b0, 2'd0, 1'b0, 1'b1, 2'd1); tick(); chk("ch1_inv", uo_out, 8'hDD);

    // Same-channel write/read hazard: old value first, new value next edge
    ui_in  = 8'h99;
    uio_in = ctl(1'b1, 2'd2, 1'b0, 1'b0, 2'd2); tick(); chk("haz_old", uo_out, 8'h33);
    ui_in  = 8'h00;
    uio_in = ctl(1'b0, 2'd0, 1'b0, 1'b0, 2'd2); tick(); chk("haz_new", uo_out, 8'h99);

    // Simultaneous write and bypass: output shows ui_in, channel loaded
    ui_in  = 8'h5C;
    uio_in = ctl(1'b1, 2'd3, 1'b1, 1'b0, 2'd0); tick(); chk("wr_byp_out", uo_out, 8'h5C);
    ui_in  = 8'h00;
    uio_in = ctl(1'b0, 2'd0, 1'b0, 1'b0, 2'd3); tick(); chk("wr_byp_ch3", uo_out, 8'h5C);

    // Reserved bit ignored
    uio_in = 8'h11; tick(); chk("rsvd_ign", uo_out, 8'h22);

    // ena gating: park on ch0, then attempt writes/sel changes with ena low
    uio_in = ctl(1'b0, 2'd0, 1'b0, 1'b0, 2'd0); tick(); chk("pre_ena", uo_out, 8'h11);
    ena = 1'b0; ui_in = 8'h77;
    uio_in = ctl(1'b1, 2'd0, 1'b0, 1'b0, 2'd1); tick(); chk("ena0_e1", uo_out, 8'h11);
    uio_in = ctl(1'b1, 2'd0, 1'b0, 1'b1, 2'd2); tick(); chk("ena0_e2", uo_out, 8'h11);
    uio_in = ctl(1'b1, 2'd0, 1'b1, 1'b0, 2'd3); tick(); chk("ena0_e3", uo_out, 8'h11);
    ena = 1'b1; ui_in = 8'h00;
    uio_in = ctl(1'b0, 2'd0, 1'b0, 1'b0, 2'd1); tick(); chk("ena1_ch1", uo_out, 8'h22);
    uio_in = ctl(1'b0, 2'd0, 1'b0, 1'b0, 2'd0); tick(); chk("ena1_ch0", uo_out, 8'h11);

    // Reset mid-operation clears channels and output
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_uo", uo_out, 8'h00);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      uio_in = ctl(1'b0, 2'd0, 1'b0, 1'b0, 2'(c));
      tick();
      chk($sformatf("post_rst_ch%0d", c), uo_out, 8'h00);
    end
    uio_in = ctl(1'b0, 2'd0, 1'b0, 1'b1, 2'd1); tick(); chk("post_rst_inv", uo_out, 8'hFF);
    chk("end_uio_out", uio_out, 8'h00);
    chk("end_uio_oe",  uio_oe,  8'h00);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
